// File: rtl/dat_tf_ctrl.sv
// Transfer sequencer for dat_phys: waits for the CMD response and for the card to
// release DAT0, launches dat_phys, and tracks the transfer to completion, timeout or abort.
module dat_tf_ctrl #(
    parameter int BLOCK_SZ_WIDTH  = 12,
    parameter int BLOCK_CNT_WIDTH = 16,
    parameter int TIMEOUT_WIDTH   = 16
) (
    input  logic                       sd_clk,
    input  logic                       rst,
    input  logic                       tf_start,
    input  logic                       tf_dir,
    input  logic [BLOCK_SZ_WIDTH-1:0]  tf_block_sz,
    input  logic [BLOCK_CNT_WIDTH-1:0] tf_block_cnt,
    input  logic [TIMEOUT_WIDTH-1:0]   timeout_val,
    input  logic                       cmd_done,
    input  logic                       cmd_err,
    input  logic                       abort,
    input  logic                       card_busy,
    input  logic                       dat_phys_busy,
    input  logic                       tf_finished,
    output logic                       write_flag,
    output logic                       read_flag,
    output logic [BLOCK_SZ_WIDTH-1:0]  block_sz,
    output logic [BLOCK_CNT_WIDTH-1:0] block_cnt,
    output logic                       ctrl_busy,
    output logic                       tf_complete,
    output logic [1:0]                 err_code
);

    typedef enum logic [2:0] {
        IDLE, WAIT_CMD, WAIT_CARD, LAUNCH, XFER, DRAIN, DONE, ERR
    } state_t;

    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_CMD     = 2'b10;
    localparam logic [1:0] ERR_ABORT   = 2'b11;

    state_t                     state;
    state_t                     next_state;
    logic                       dir_q;
    logic [TIMEOUT_WIDTH-1:0]   timeout_q;
    logic [TIMEOUT_WIDTH-1:0]   tmo_cnt;
    logic [1:0]                 err_set;
    logic                       tmo_hit;
    logic                       in_wait;

    // A zero timeout value disables the per-state timeout entirely.
    assign tmo_hit = (timeout_q != '0) && (tmo_cnt == timeout_q - TIMEOUT_WIDTH'(1));
    assign in_wait = (state == WAIT_CMD) || (state == WAIT_CARD) || (state == LAUNCH);

    always_comb begin
        next_state = state;
        err_set    = ERR_ABORT;
        case (state)
            IDLE: begin
                if (tf_start)
                    next_state = (tf_block_cnt == '0) ? DONE : WAIT_CMD;
            end
            WAIT_CMD: begin
                if (abort)
                    next_state = dat_phys_busy ? DRAIN : ERR;
                else if (cmd_err) begin
                    next_state = ERR;
                    err_set    = ERR_CMD;
                end else if (cmd_done)
                    next_state = dir_q ? WAIT_CARD : LAUNCH;
                else if (tmo_hit) begin
                    next_state = ERR;
                    err_set    = ERR_TIMEOUT;
                end
            end
            WAIT_CARD: begin
                if (abort)
                    next_state = dat_phys_busy ? DRAIN : ERR;
                else if (!card_busy)
                    next_state = LAUNCH;
                else if (tmo_hit) begin
                    next_state = ERR;
                    err_set    = ERR_TIMEOUT;
                end
            end
            LAUNCH: begin
                if (abort)
                    next_state = dat_phys_busy ? DRAIN : ERR;
                else if (dat_phys_busy)
                    next_state = XFER;
                else if (tmo_hit) begin
                    next_state = ERR;
                    err_set    = ERR_TIMEOUT;
                end
            end
            XFER: begin
                // A read ends when dat_phys goes idle without a tf_finished pulse.
                if (abort)
                    next_state = dat_phys_busy ? DRAIN : ERR;
                else if (tf_finished || !dat_phys_busy)
                    next_state = DONE;
            end
            DRAIN: begin
                if (!dat_phys_busy)
                    next_state = ERR;
            end
            DONE:    next_state = IDLE;
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge sd_clk) begin
        if (rst) begin
            state     <= IDLE;
            dir_q     <= 1'b0;
            block_sz  <= '0;
            block_cnt <= '0;
            timeout_q <= '0;
            tmo_cnt   <= '0;
            err_code  <= 2'b00;
        end else begin
            state <= next_state;
            if (state == IDLE && tf_start) begin
                dir_q     <= tf_dir;
                block_sz  <= tf_block_sz;
                block_cnt <= tf_block_cnt;
                timeout_q <= timeout_val;
                err_code  <= 2'b00;
            end
            if (next_state == ERR)
                err_code <= err_set;
            // Counter restarts on every state change so each wait state gets a full budget.
            if (next_state != state || !in_wait)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + TIMEOUT_WIDTH'(1);
        end
    end

    assign write_flag  = (state == LAUNCH) && dir_q;
    assign read_flag   = (state == LAUNCH) && !dir_q;
    assign ctrl_busy   = (state != IDLE);
    assign tf_complete = (state == DONE);

endmodule
